// File: rtl/src_fifo_pkg.sv
// Shared types and helpers for the narrow-to-wide packing FIFO.
package src_fifo_pkg;

    typedef logic [31:0] count_t;

    // Pointer width for a storage of `depth` entries (at least one bit).
    function automatic int ptr_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // Mask with the low `ratio` bits set; callers slice the width they need.
    function automatic logic [255:0] all_lanes(input int ratio);
        logic [255:0] m;
        m = '0;
        for (int i = 0; i < 256; i++) begin
            if (i < ratio) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/src_fifo_ram.sv
// Entry storage: DEPTH x W register array, synchronous write, asynchronous read.
module src_fifo_ram
    import src_fifo_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4,
    parameter int AW    = ptr_w(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [W-1:0]  wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [W-1:0]  rd_data_o
);

    logic [W-1:0] mem_q [DEPTH];

    // Write one entry per cycle when enabled.
    // NOTE: storage has no reset; the count says which entries are meaningful,
    // so clearing the array would only cost reset fan-out. Non-blocking (<=)
    // keeps every flop update ordered against the edge, not against code order.
    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/src_pack_fifo.sv
// Narrow-to-wide packing FIFO: RATIO words of IN_W bits form one entry.
// Define SRC_PACK_FIFO_FWFT_EN for first-word-fall-through reads; the default
// build registers read data one cycle after a pop.
module src_pack_fifo
    import src_fifo_pkg::*;
#(
    parameter int IN_W  = 32,
    parameter int RATIO = 16,
    parameter int DEPTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IN_W-1:0]       din,
    input  logic                  we,
    input  logic                  flush,
    output logic                  full,
    output logic [31:0]           wr_count,
    input  logic                  re,
    output logic [IN_W*RATIO-1:0] q,
    output logic [RATIO-1:0]      q_lanes,
    output logic                  valid,
    output logic                  empty,
    output logic [31:0]           rd_count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int OUT_W = IN_W * RATIO;
    localparam int LW    = $clog2(RATIO);
    localparam int PW    = ptr_w(DEPTH);
    localparam int CW    = PW + 1;
    localparam logic [255:0]     ALL_LANES = all_lanes(RATIO);
    localparam logic [RATIO-1:0] FULL_MASK = ALL_LANES[RATIO-1:0];

    logic [OUT_W-1:0] pack_q, pack_d;
    logic [LW-1:0]    lane_q, lane_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d, udf_q, udf_d;

    logic             full_w, empty_w, wr_ok, last_lane, commit, pop;
    logic [OUT_W-1:0] entry_data, head_data;
    logic [RATIO-1:0] entry_mask, head_lanes;

    // Status comes from the registered count only, so a pop never frees room
    // for a write in the same cycle.
    assign full_w    = (cnt_q == CW'(DEPTH));
    assign empty_w   = (cnt_q == '0);
    assign wr_ok     = we && !full_w;
    assign last_lane = (lane_q == LW'(RATIO - 1));
    assign commit    = (wr_ok && last_lane) || (flush && !full_w && (lane_q != '0 || we));
    assign pop       = re && !empty_w;

    // Merge the incoming word into the pending entry and derive every next state.
    // NOTE: every variable gets a default before any branch, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        int n_fill;
        entry_data = pack_q;
        n_fill     = int'(lane_q) + (wr_ok ? 1 : 0);
        if (wr_ok) entry_data[int'(lane_q)*IN_W +: IN_W] = din;
        entry_mask = FULL_MASK >> (RATIO - n_fill);

        pack_d   = commit ? '0 : entry_data;
        lane_d   = commit ? '0 : (wr_ok ? lane_q + LW'(1) : lane_q);
        wr_ptr_d = wr_ptr_q + PW'(commit);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        cnt_d    = cnt_q + CW'(commit) - CW'(pop);
        ovf_d    = ovf_q || ((we || flush) && full_w);
        udf_d    = udf_q || (re && empty_w);
    end

    // Register the pack buffer, lane counter, pointers, count and sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            pack_q   <= '0;
            lane_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            pack_q   <= pack_d;
            lane_q   <= lane_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    src_fifo_ram #(
        .W     (OUT_W + RATIO),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (commit),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i ({entry_mask, entry_data}),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o ({head_lanes, head_data})
    );

`ifdef SRC_PACK_FIFO_FWFT_EN
    // Head is visible combinationally; forced to zero while nothing is stored.
    assign q       = empty_w ? '0 : head_data;
    assign q_lanes = empty_w ? '0 : head_lanes;
    assign valid   = !empty_w;
`else
    logic [OUT_W-1:0] rdata_q;
    logic [RATIO-1:0] rlanes_q;
    logic             rvalid_q;

    // Capture the popped head; valid pulses for the cycle after each pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q  <= '0;
            rlanes_q <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= pop;
            if (pop) begin
                rdata_q  <= head_data;
                rlanes_q <= head_lanes;
            end
        end
    end

    assign q       = rdata_q;
    assign q_lanes = rlanes_q;
    assign valid   = rvalid_q;
`endif

    assign full      = full_w;
    assign empty     = empty_w;
    assign rd_count  = count_t'(cnt_q);
    assign wr_count  = count_t'(cnt_q) * count_t'(RATIO) + count_t'(lane_q);
    assign overflow  = ovf_q;
    assign underflow = udf_q;

endmodule

// File: tb/tb_src_pack_fifo.sv
// Self-checking bench for src_pack_fifo (IN_W=32, RATIO=4, DEPTH=4).
module tb_src_pack_fifo;

    localparam int IN_W  = 32;
    localparam int RATIO = 4;
    localparam int DEPTH = 4;
    localparam int OUT_W = IN_W * RATIO;

    typedef struct {
        logic [OUT_W-1:0] data;
        logic [RATIO-1:0] lanes;
    } ent_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [IN_W-1:0]  din = '0;
    logic             we = 1'b0, flush = 1'b0, re = 1'b0;
    logic             full, valid, empty, overflow, underflow;
    logic [31:0]      wr_count, rd_count;
    logic [OUT_W-1:0] q;
    logic [RATIO-1:0] q_lanes;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: list of stored entries plus list of pending words.
    ent_t             mq[$];
    logic [IN_W-1:0]  pend[$];
    logic             m_ovf = 1'b0, m_udf = 1'b0;
    logic [OUT_W-1:0] m_q = '0;
    logic [RATIO-1:0] m_lanes = '0;
    logic             m_valid = 1'b0;

    src_pack_fifo #(.IN_W(IN_W), .RATIO(RATIO), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .din(din), .we(we), .flush(flush), .full(full),
        .wr_count(wr_count), .re(re), .q(q), .q_lanes(q_lanes), .valid(valid),
        .empty(empty), .rd_count(rd_count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        mq.delete();
        pend.delete();
        m_ovf = 1'b0; m_udf = 1'b0;
        m_q = '0; m_lanes = '0; m_valid = 1'b0;
    endtask

    task automatic model_commit();
        ent_t e;
        e.data = '0; e.lanes = '0;
        foreach (pend[k]) begin
            e.data[k*IN_W +: IN_W] = pend[k];
            e.lanes[k] = 1'b1;
        end
        mq.push_back(e);
        pend.delete();
    endtask

    task automatic model_step(input logic w, input logic f, input logic r, input logic [IN_W-1:0] d);
        bit   full0, empty0;
        ent_t h;
        full0  = (mq.size() == DEPTH);
        empty0 = (mq.size() == 0);
        if ((w || f) && full0) m_ovf = 1'b1;
        if (r && empty0) m_udf = 1'b1;
        m_valid = 1'b0;
        if (r && !empty0) begin
            h = mq.pop_front();
            m_q = h.data; m_lanes = h.lanes; m_valid = 1'b1;
        end
        if (!full0) begin
            if (w) pend.push_back(d);
            if (pend.size() == RATIO || (f && pend.size() > 0)) model_commit();
        end
    endtask

    task automatic check_all();
        check("rd_count", rd_count, mq.size());
        check("wr_count", wr_count, mq.size() * RATIO + pend.size());
        check("empty", empty, mq.size() == 0);
        check("full", full, mq.size() == DEPTH);
        check("overflow", overflow, m_ovf);
        check("underflow", underflow, m_udf);
`ifdef SRC_PACK_FIFO_FWFT_EN
        check("valid", valid, mq.size() > 0);
        check("q", q, (mq.size() > 0) ? mq[0].data : '0);
        check("q_lanes", q_lanes, (mq.size() > 0) ? mq[0].lanes : '0);
`else
        check("valid", valid, m_valid);
        check("q", q, m_q);
        check("q_lanes", q_lanes, m_lanes);
`endif
    endtask

    task automatic cyc(input logic w, input logic f, input logic r, input logic [IN_W-1:0] d);
        we = w; flush = f; re = r; din = d;
        model_step(w, f, r, d);
        @(posedge clk); #1;
        we = 1'b0; flush = 1'b0; re = 1'b0;
        check_all();
    endtask

    task automatic reset_dut();
        rst = 1'b1; we = 1'b0; flush = 1'b0; re = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        check_all();
    endtask

    // Check a known head entry, then pop it (order depends on read mode).
    task automatic expect_head(input string tag, input logic [OUT_W-1:0] data, input logic [RATIO-1:0] lanes);
`ifdef SRC_PACK_FIFO_FWFT_EN
        check({tag, "_q"}, q, data);
        check({tag, "_lanes"}, q_lanes, lanes);
        cyc(1'b0, 1'b0, 1'b1, '0);
`else
        cyc(1'b0, 1'b0, 1'b1, '0);
        check({tag, "_q"}, q, data);
        check({tag, "_lanes"}, q_lanes, lanes);
        check({tag, "_valid"}, valid, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, '0);
        check({tag, "_valid_drop"}, valid, 1'b0);
`endif
    endtask

    initial begin
        reset_dut();
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_rd_count", rd_count, 0);

        // Four words pack into one full entry.
        for (int i = 1; i <= 4; i++) cyc(1'b1, 1'b0, 1'b0, i);
        check("pack_rd_count", rd_count, 1);
        expect_head("pack", 128'h00000004_00000003_00000002_00000001, 4'hF);

        // Partial entry committed by a separate flush.
        cyc(1'b1, 1'b0, 1'b0, 32'hA);
        cyc(1'b1, 1'b0, 1'b0, 32'hB);
        cyc(1'b0, 1'b1, 1'b0, '0);
        expect_head("flush2", 128'h0000000B_0000000A, 4'h3);

        // Flush with a same-cycle write; then a lone flush is a no-op.
        cyc(1'b1, 1'b1, 1'b0, 32'hC);
        expect_head("flush1", 128'hC, 4'h1);
        cyc(1'b0, 1'b1, 1'b0, '0);
        check("noop_flush", rd_count, 0);

        // Fill to full, then a blocked write sets overflow.
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 1'b0, 32'h100 + i);
        check("fill_full", full, 1'b1);
        check("fill_wr_count", wr_count, 16);
        cyc(1'b1, 1'b0, 1'b0, 32'hDEAD);
        check("ovf_set", overflow, 1'b1);

        // Pop and blocked write in the same cycle.
        cyc(1'b1, 1'b0, 1'b1, 32'hBEEF);
        check("rw_full_rd_count", rd_count, 3);
        check("rw_full_wr_count", wr_count, 12);

        // Drain, then read while empty.
        repeat (3) cyc(1'b0, 1'b0, 1'b1, '0);
        cyc(1'b0, 1'b0, 1'b1, '0);
        check("udf_set", underflow, 1'b1);
        check("udf_rd_count", rd_count, 0);

        // Reset with a partially packed entry pending.
        reset_dut();
        cyc(1'b1, 1'b0, 1'b0, 32'h11);
        cyc(1'b1, 1'b0, 1'b0, 32'h22);
        check("mid_wr_count", wr_count, 2);
        reset_dut();
        check("mid_rst_wr_count", wr_count, 0);
        check("mid_rst_empty", empty, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 32'h50 + i);
        expect_head("clean", 128'h00000053_00000052_00000051_00000050, 4'hF);

        // Randomized traffic against the model.
        reset_dut();
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(63) == 0) reset_dut();
            else cyc($urandom_range(99) < 60, $urandom_range(99) < 15,
                     $urandom_range(99) < 40, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
